// File: rtl/mem_wr_pipe.sv
// rtl/mem_wr_pipe.sv - MEM-to-WB stage register with valid/ready flow control, optional skid buffer, flush and stall
module mem_wr_pipe #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CLR_MASK = {CTRL_W{1'b0}},
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              skid_full;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              accept;
  logic              consume;

  // With the skid buffer, in_ready depends only on state, never on out_ready.
  assign in_ready  = rst ? 1'b0 : ((SKID != 0) ? ~skid_full : (~out_valid | out_ready));
  assign accept    = in_valid & in_ready & ~stall & ~flush;
  assign consume   = out_valid & out_ready & ~stall;
  assign occupancy = {1'b0, out_valid} + {1'b0, skid_full};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_ctrl <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

      if (flush) begin
        out_valid <= 1'b0;
        skid_full <= 1'b0;
        out_ctrl  <= '0;
      end else if (stall) begin
        out_ctrl <= out_ctrl & ~CLR_MASK;
      end else if (!out_valid || consume) begin
        // Main slot frees up: the older skid bundle always goes first.
        if (skid_full) begin
          out_data  <= skid_data;
          out_ctrl  <= skid_ctrl;
          out_valid <= 1'b1;
          if (accept) begin
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
          end else begin
            skid_full <= 1'b0;
          end
        end else if (accept) begin
          out_data  <= in_data;
          out_ctrl  <= in_ctrl;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept && (SKID != 0)) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
        skid_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_wr_pipe.sv
// tb/tb_mem_wr_pipe.sv - directed table-driven bench for mem_wr_pipe (SKID=1, SKID=0 and narrow-counter instances)
module tb_mem_wr_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_ready;
  logic        stall;
  logic        flush;

  logic        ir1, ov1, ir0, ov0, ir2, ov2;
  logic [31:0] od1, od0, od2;
  logic [15:0] oc1, oc0, oc2;
  logic [1:0]  occ1, occ0, occ2;
  logic [15:0] cnt1, cnt0;
  logic [1:0]  cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wr_pipe #(.DATA_W(32), .CTRL_W(16), .CLR_MASK(16'h0007), .SKID(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ctrl(oc1),
    .stall(stall), .flush(flush), .occupancy(occ1), .stall_cnt(cnt1));

  mem_wr_pipe #(.DATA_W(32), .CTRL_W(16), .CLR_MASK(16'h0007), .SKID(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ctrl(oc0),
    .stall(stall), .flush(flush), .occupancy(occ0), .stall_cnt(cnt0));

  mem_wr_pipe #(.DATA_W(32), .CTRL_W(16), .CLR_MASK(16'h0007), .SKID(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_ctrl(oc2),
    .stall(stall), .flush(flush), .occupancy(occ2), .stall_cnt(cnt2));

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [15:0] c;
    logic        rdy, st, fl;
    logic        ov;
    logic [31:0] od;
    logic [15:0] oc;
    logic [1:0]  occ;
    logic        ir;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [31:0] d, input logic [15:0] c,
                     input logic rdy, input logic st, input logic fl,
                     input logic ov, input logic [31:0] od, input logic [15:0] oc,
                     input logic [1:0] occ, input logic ir, input logic [15:0] cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.rdy = rdy; v.st = st; v.fl = fl;
    v.ov = ov; v.od = od; v.oc = oc; v.occ = occ; v.ir = ir; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [15:0] c,
                       input logic rdy, input logic st, input logic fl);
    in_valid = iv; in_data = d; in_ctrl = c; out_ready = rdy; stall = st; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check("rst_ov", ov1, 0);
    check("rst_od", od1, 0);
    check("rst_oc", oc1, 0);
    check("rst_occ", occ1, 0);
    check("rst_cnt", cnt1, 0);
    check("rst_ir_skid", ir1, 0);
    check("rst_ir_noskid", ir0, 0);
    rst = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    #1;
    check("post_rst_ir_skid", ir1, 1);
    check("post_rst_ir_noskid", ir0, 1);

    // streaming
    for (int i = 0; i < 8; i++)
      add(1, 32'h11 + i, 16'h0100 + i[15:0], 1, 0, 0, 1, 32'h11 + i, 16'h0100 + i[15:0], 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,            0, 32'h18, 16'h0107, 0, 1, 0);
    // backpressure
    add(1, 32'hA1, 16'h00A1, 0, 0, 0, 1, 32'hA1, 16'h00A1, 1, 1, 0);
    add(1, 32'hA2, 16'h00A2, 0, 0, 0, 1, 32'hA1, 16'h00A1, 2, 0, 0);
    add(1, 32'hA3, 16'h00A3, 0, 0, 0, 1, 32'hA1, 16'h00A1, 2, 0, 0);
    add(1, 32'hA3, 16'h00A3, 1, 0, 0, 1, 32'hA2, 16'h00A2, 1, 1, 0);
    add(1, 32'hA3, 16'h00A3, 1, 0, 0, 1, 32'hA3, 16'h00A3, 1, 1, 0);
    add(0, 0, 0, 1, 0, 0,            0, 32'hA3, 16'h00A3, 0, 1, 0);
    // stall clears masked ctrl bits, holds data, blocks consume
    add(1, 32'hC1, 16'h00FF, 1, 0, 0, 1, 32'hC1, 16'h00FF, 1, 1, 0);
    add(1, 32'hC2, 16'h1234, 1, 1, 0, 1, 32'hC1, 16'h00F8, 1, 1, 1);
    add(1, 32'hC2, 16'h1234, 1, 1, 0, 1, 32'hC1, 16'h00F8, 1, 1, 2);
    add(1, 32'hC2, 16'h1234, 1, 1, 0, 1, 32'hC1, 16'h00F8, 1, 1, 3);
    add(1, 32'hC2, 16'h1234, 1, 0, 0, 1, 32'hC2, 16'h1234, 1, 1, 3);
    add(0, 0, 0, 1, 0, 0,            0, 32'hC2, 16'h1234, 0, 1, 3);
    // flush from full, then flush over an otherwise valid accept
    add(1, 32'hB1, 16'h00B1, 0, 0, 0, 1, 32'hB1, 16'h00B1, 1, 1, 3);
    add(1, 32'hB2, 16'h00B2, 0, 0, 0, 1, 32'hB1, 16'h00B1, 2, 0, 3);
    add(1, 32'hB3, 16'h00B3, 0, 0, 1, 0, 32'hB1, 16'h0000, 0, 1, 3);
    add(0, 0, 0, 1, 0, 0,            0, 32'hB1, 16'h0000, 0, 1, 3);
    add(1, 32'hB4, 16'h00B4, 1, 0, 1, 0, 32'hB1, 16'h0000, 0, 1, 3);
    add(0, 0, 0, 1, 0, 0,            0, 32'hB1, 16'h0000, 0, 1, 3);
    add(0, 0, 0, 1, 1, 1,            0, 32'hB1, 16'h0000, 0, 1, 4);
    add(0, 0, 0, 1, 1, 0,            0, 32'hB1, 16'h0000, 0, 1, 5);
    // fill to occupancy 2 ahead of the reset
    add(1, 32'hE1, 16'h00E1, 0, 0, 0, 1, 32'hE1, 16'h00E1, 1, 1, 5);
    add(1, 32'hE2, 16'h00E2, 0, 0, 0, 1, 32'hE1, 16'h00E1, 2, 0, 5);

    foreach (vecs[k]) begin
      drive(vecs[k].iv, vecs[k].d, vecs[k].c, vecs[k].rdy, vecs[k].st, vecs[k].fl);
      tick();
      check($sformatf("v%0d_ov", k), ov1, vecs[k].ov);
      check($sformatf("v%0d_od", k), od1, vecs[k].od);
      check($sformatf("v%0d_oc", k), oc1, vecs[k].oc);
      check($sformatf("v%0d_occ", k), occ1, vecs[k].occ);
      check($sformatf("v%0d_ir", k), ir1, vecs[k].ir);
      check($sformatf("v%0d_cnt", k), cnt1, vecs[k].cnt);
    end
    check("narrow_cnt_sat_pre_rst", cnt2, 3);

    // reset mid-operation at occupancy 2, stall_cnt 5
    rst = 1'b1;
    drive(1, 32'hF1, 16'h00F1, 1, 1, 1);
    tick();
    check("midrst_ov", ov1, 0);
    check("midrst_od", od1, 0);
    check("midrst_oc", oc1, 0);
    check("midrst_occ", occ1, 0);
    check("midrst_cnt", cnt1, 0);
    check("midrst_ir", ir1, 0);
    check("midrst_cnt_narrow", cnt2, 0);
    rst = 1'b0;
    drive(0, 0, 0, 1, 0, 0);
    #1;
    check("midrst_ir_after", ir1, 1);

    // narrow counter saturation
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 0, 1, 1, 0);
      tick();
      check($sformatf("sat%0d_narrow", k), cnt2, (k > 3) ? 3 : k);
      check($sformatf("sat%0d_wide", k), cnt1, k);
    end

    // SKID=0: out_ready 1,0,1,1 with continuous in_valid
    drive(1, 32'hD1, 16'h00D1, 1, 0, 0); #1;
    check("ns_ir_a", ir0, 1);
    tick();
    check("ns_ov_a", ov0, 1);
    check("ns_od_a", od0, 32'hD1);
    drive(1, 32'hD2, 16'h00D2, 0, 0, 0); #1;
    check("ns_ir_b", ir0, 0);
    tick();
    check("ns_od_b", od0, 32'hD1);
    check("ns_occ_b", occ0, 1);
    drive(1, 32'hD2, 16'h00D2, 1, 0, 0); #1;
    check("ns_ir_c", ir0, 1);
    tick();
    check("ns_od_c", od0, 32'hD2);
    check("ns_oc_c", oc0, 16'h00D2);
    drive(1, 32'hD3, 16'h00D3, 1, 0, 0); #1;
    check("ns_ir_d", ir0, 1);
    tick();
    check("ns_od_d", od0, 32'hD3);
    drive(0, 0, 0, 1, 0, 0);
    tick();
    check("ns_ov_e", ov0, 0);
    check("ns_occ_e", occ0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
